// File: rtl/pal_pkg.sv
// Shared definitions for the registered PAL: FSM state encoding, image
// length and field-offset helpers for the configuration image.
package pal_pkg;

  // Loader FSM encoding, kept as plain constants for legacy compatibility.
  typedef logic [1:0] pal_state_t;
  localparam pal_state_t ST_UNCFG  = 2'd0;
  localparam pal_state_t ST_LOAD   = 2'd1;
  localparam pal_state_t ST_ACTIVE = 2'd2;
  localparam pal_state_t ST_RELOAD = 2'd3;

  // Offsets of the two macrocell control bits inside each 2-bit MC field.
  localparam int MC_REG_OFS = 0;
  localparam int MC_INV_OFS = 1;

  // Total image length: AND plane, OR plane, then macrocell controls.
  function automatic int sr_len(input int n, input int m, input int p);
    return 2 * (n + m) * p + p * m + 2 * m;
  endfunction

  // AND-plane crosspoint for product term p_idx and column col.
  // Even columns are the true source, odd columns its complement.
  function automatic int and_idx(input int p_idx, input int col, input int p);
    return p_idx + col * p;
  endfunction

  // OR-plane crosspoint connecting product term p_idx to sum m_idx.
  function automatic int or_idx(input int p_idx, input int m_idx,
                                input int n, input int m, input int p);
    return 2 * (n + m) * p + p_idx + m_idx * p;
  endfunction

  // Base of the 2-bit macrocell field for output m_idx.
  function automatic int mc_idx(input int m_idx, input int n, input int m,
                                input int p);
    return 2 * (n + m) * p + p * m + 2 * m_idx;
  endfunction

endpackage

// File: rtl/pal_if.sv
// Bus bundle of the registered PAL: serial configuration port, array
// inputs and macrocell outputs plus loader status.
interface pal_if #(
  parameter int N = 8,
  parameter int M = 8
);

  logic         cfg_en;
  logic         cfg_in;
  logic [N-1:0] input_vars;
  logic [M-1:0] output_vals;
  logic         cfg_done;
  logic         cfg_valid;

  // Driver side (system / testbench).
  modport master (
    output cfg_en, cfg_in, input_vars,
    input  output_vals, cfg_done, cfg_valid
  );

  // PAL side.
  modport slave (
    input  cfg_en, cfg_in, input_vars,
    output output_vals, cfg_done, cfg_valid
  );

endinterface

// File: rtl/pal_cfg_loader.sv
// Serial configuration loader: shadow shift chain, bit counter, load FSM
// and the commit strobe that swaps a complete image into the array.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int SR_LEN = 336
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_in,
  output logic              commit,
  output logic [SR_LEN-1:0] image,
  output logic              running,
  output logic              cfg_done,
  output logic              cfg_valid
);

  localparam int CW = $clog2(SR_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(SR_LEN - 1);

  pal_state_t          state;
  logic [CW-1:0]       cnt;
  // The final bit goes straight from cfg_in into the active register on the
  // commit edge, so only SR_LEN-1 bits of the shadow chain are ever stored.
  logic [SR_LEN-2:0]   sh;
  logic                loading;

  assign loading = (state == ST_LOAD) || (state == ST_RELOAD);
  assign commit  = loading && cfg_en && (cnt == CNT_LAST);
  assign image   = {sh, cfg_in};
  assign running = (state == ST_ACTIVE) || (state == ST_RELOAD);

  // Shift chain, bit counter, FSM and status flags.
  // NOTE: all state here is updated with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_UNCFG;
      cnt       <= '0;
      sh        <= '0;
      cfg_done  <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      cfg_done <= commit;
      if (cfg_en) begin
        sh <= image[SR_LEN-2:0];
      end
      case (state)
        ST_UNCFG: begin
          if (cfg_en) begin
            state <= ST_LOAD;
            cnt   <= CW'(1);
          end
        end
        ST_ACTIVE: begin
          if (cfg_en) begin
            state <= ST_RELOAD;
            cnt   <= CW'(1);
          end
        end
        ST_LOAD, ST_RELOAD: begin
          if (!cfg_en) begin
            // Abort: partial image discarded, fall back to previous mode.
            state <= (state == ST_LOAD) ? ST_UNCFG : ST_ACTIVE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_ACTIVE;
            cnt       <= '0;
            cfg_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_UNCFG;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pal_registered.sv
// Registered PAL: programmable AND/OR array with per-output macrocells,
// registered feedback into the AND plane and a double-buffered loader.
module pal_registered
  import pal_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8
) (
  input logic clk,
  input logic rst,
  pal_if.slave bus
);

  localparam int SR_LEN = sr_len(N, M, P);
  localparam int NS     = N + M;

  logic [SR_LEN-1:0]           act;
  logic [SR_LEN-1:0]           image;
  logic                        commit;
  logic                        running;
  logic                        cfg_done;
  logic                        cfg_valid;
  logic [M-1:0]                q;
  logic [NS-1:0]               src;
  logic [2*NS-1:0]             cols;
  logic [P-1:0][2*NS-1:0]      and_conn;
  logic [M-1:0][P-1:0]         or_conn;
  logic [P-1:0]                terms;
  logic [M-1:0]                sums;
  logic [M-1:0]                mc_reg;
  logic [M-1:0]                mc_inv;
  logic [M-1:0]                out_vals;

  pal_cfg_loader #(
    .SR_LEN (SR_LEN)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (bus.cfg_en),
    .cfg_in    (bus.cfg_in),
    .commit    (commit),
    .image     (image),
    .running   (running),
    .cfg_done  (cfg_done),
    .cfg_valid (cfg_valid)
  );

  assign bus.cfg_done  = cfg_done;
  assign bus.cfg_valid = cfg_valid;

  // Feedback always comes from the flops, so the array has no comb loops.
  assign src = {q, bus.input_vars};

  for (genvar s = 0; s < NS; s++) begin : g_cols
    assign cols[2*s]   = src[s];
    assign cols[2*s+1] = ~src[s];
  end

  // Product terms: AND of connected columns; a blank term stays 0.
  for (genvar p = 0; p < P; p++) begin : g_and
    for (genvar c = 0; c < 2 * NS; c++) begin : g_col
      assign and_conn[p][c] = act[and_idx(p, c, P)];
    end
    assign terms[p] = (|and_conn[p]) & (&(~and_conn[p] | cols));
  end

  // Sums: OR of connected product terms, plus macrocell control bits.
  for (genvar m = 0; m < M; m++) begin : g_or
    for (genvar p = 0; p < P; p++) begin : g_term
      assign or_conn[m][p] = act[or_idx(p, m, N, M, P)];
    end
    assign sums[m]   = |(or_conn[m] & terms);
    assign mc_reg[m] = act[mc_idx(m, N, M, P) + MC_REG_OFS];
    assign mc_inv[m] = act[mc_idx(m, N, M, P) + MC_INV_OFS];
  end

  // Active image register: swapped atomically on the commit edge.
  // NOTE: the image is a plain flop bank, not a RAM, so resetting it is cheap
  // and guarantees the array is blank until the first image commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= '0;
    end else if (commit) begin
      act <= image;
    end
  end

  // Macrocell flops: track the sums while configured, cleared on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (commit) begin
      q <= '0;
    end else if (running) begin
      q <= sums;
    end
  end

  // Output select and polarity; forced low until an image is active.
  // NOTE: out_vals gets a default before any branch so no latch is inferred.
  always_comb begin
    out_vals = '0;
    if (running) begin
      out_vals = ((mc_reg & q) | (~mc_reg & sums)) ^ mc_inv;
    end
  end

  assign bus.output_vals = out_vals;

endmodule

// File: tb/tb_pal_registered.sv
// Directed testbench for pal_registered at N=M=P=8 (336-bit image).
module tb_pal_registered;

  localparam int N      = 8;
  localparam int M      = 8;
  localparam int P      = 8;
  localparam int SR_LEN = 336;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pal_if #(.N(N), .M(M)) bus ();

  pal_registered #(.N(N), .M(M), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_seen = 0;
  int base  = 0;

  logic [SR_LEN-1:0] img_a;
  logic [SR_LEN-1:0] img_b;
  logic [M-1:0]      pre_out;
  logic              pre_done;
  logic              pre_valid;
  int                pre_cyc;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.cfg_done === 1'b1) done_seen <= done_seen + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shift nbits of img, MSB first, leaving cfg_en high afterwards.
  // Snapshots the DUT state in the cycle that presents the last bit.
  task automatic shift_bits(input logic [SR_LEN-1:0] img, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = img[SR_LEN-1-i];
      if (i == nbits - 1) begin
        #1;
        pre_out   = bus.output_vals;
        pre_done  = bus.cfg_done;
        pre_valid = bus.cfg_valid;
        pre_cyc   = cyc;
      end
      step(1);
    end
  endtask

  function automatic logic phase(input int c);
    return ((c - base) % 2) == 1;
  endfunction

  task automatic test_reset();
    logic [7:0] pats [4] = '{8'hFF, 8'h01, 8'hA5, 8'h3C};
    rst = 1'b1; bus.cfg_en = 1'b0; bus.cfg_in = 1'b0; bus.input_vars = '0;
    step(2);
    total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL reset_out: got %b want %b", bus.output_vals, 8'h00); end
    total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.cfg_valid); end
    total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.cfg_done); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.input_vars = pats[i];
      step(1);
      total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL uncfg_out[%0d]: got %b want %b", i, bus.output_vals, 8'h00); end
    end
    total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL uncfg_valid: got %b want 0", bus.cfg_valid); end
  endtask

  task automatic test_load_comb_reg();
    bus.input_vars = 8'h00;
    shift_bits(img_a, SR_LEN);
    bus.cfg_en = 1'b0;
    total++; if (pre_done !== 1'b0) begin bad++; $display("FAIL load_early_done: got %b want 0", pre_done); end
    total++; if (pre_valid !== 1'b0) begin bad++; $display("FAIL load_early_valid: got %b want 0", pre_valid); end
    total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL load_done: got %b want 1", bus.cfg_done); end
    total++; if (bus.cfg_valid !== 1'b1) begin bad++; $display("FAIL load_valid: got %b want 1", bus.cfg_valid); end
    total++; if (bus.output_vals !== 8'b0000_0100) begin bad++; $display("FAIL load_out_idle: got %b want %b", bus.output_vals, 8'b0000_0100); end
    bus.input_vars = 8'h01; #1;
    total++; if (bus.output_vals !== 8'b0000_0101) begin bad++; $display("FAIL comb_same_cycle: got %b want %b", bus.output_vals, 8'b0000_0101); end
    step(1);
    total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", bus.cfg_done); end
    total++; if (bus.output_vals !== 8'b0000_0111) begin bad++; $display("FAIL reg_next_cycle: got %b want %b", bus.output_vals, 8'b0000_0111); end
    bus.input_vars = 8'h03; #1;
    total++; if (bus.output_vals !== 8'b0000_0110) begin bad++; $display("FAIL comb_i11: got %b want %b", bus.output_vals, 8'b0000_0110); end
    step(1);
    total++; if (bus.output_vals !== 8'b0000_0100) begin bad++; $display("FAIL reg_i11: got %b want %b", bus.output_vals, 8'b0000_0100); end
  endtask

  task automatic test_inv_blank();
    logic [7:0] pats [6] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h02, 8'h01};
    logic [7:0] pat;
    logic       e;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      pat = pats[i];
      bus.input_vars = pat;
      step(1);
      e   = pat[0] & ~pat[1];
      exp = {5'b0, 1'b0, 1'b1, e, e};
      total++; if (bus.output_vals !== exp) begin bad++; $display("FAIL inv_blank[%0d]: got %b want %b", i, bus.output_vals, exp); end
    end
  endtask

  task automatic test_feedback();
    logic [7:0] exp;
    bus.input_vars = 8'h01;
    step(1);
    shift_bits(img_b, SR_LEN);
    bus.cfg_en = 1'b0;
    base = cyc;
    total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL fb_done: got %b want 1", bus.cfg_done); end
    total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL fb_q_cleared: got %b want %b", bus.output_vals, 8'h00); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      exp = {7'b0, k[0]};
      total++; if (bus.output_vals !== exp) begin bad++; $display("FAIL fb_toggle[%0d]: got %b want %b", k, bus.output_vals, exp); end
    end
  endtask

  task automatic test_reload_abort();
    int d0;
    logic [7:0] exp;
    bus.input_vars = 8'h01;
    d0 = done_seen;
    shift_bits(img_a, 100);
    bus.cfg_en = 1'b0;
    step(2);
    exp = {7'b0, phase(cyc)};
    total++; if (done_seen !== d0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen - d0); end
    total++; if (bus.cfg_valid !== 1'b1) begin bad++; $display("FAIL abort_valid: got %b want 1", bus.cfg_valid); end
    total++; if (bus.output_vals !== exp) begin bad++; $display("FAIL abort_old_image: got %b want %b", bus.output_vals, exp); end
    shift_bits(img_a, SR_LEN);
    bus.cfg_en = 1'b0;
    exp = {7'b0, phase(pre_cyc)};
    total++; if (pre_out !== exp) begin bad++; $display("FAIL reload_old_until_commit: got %b want %b", pre_out, exp); end
    total++; if (pre_done !== 1'b0) begin bad++; $display("FAIL reload_early_done: got %b want 0", pre_done); end
    total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL reload_done: got %b want 1", bus.cfg_done); end
    total++; if (bus.output_vals !== 8'b0000_0101) begin bad++; $display("FAIL reload_swap: got %b want %b", bus.output_vals, 8'b0000_0101); end
    step(1);
    total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL reload_done_width: got %b want 0", bus.cfg_done); end
    total++; if (bus.output_vals !== 8'b0000_0111) begin bad++; $display("FAIL reload_reg: got %b want %b", bus.output_vals, 8'b0000_0111); end
    total++; if (done_seen !== d0 + 1) begin bad++; $display("FAIL reload_pulse_count: got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_reset_mid_reload();
    bus.input_vars = 8'h01;
    shift_bits(img_b, 199);
    bus.cfg_en = 1'b1;
    bus.cfg_in = img_b[SR_LEN-200];
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.cfg_en = 1'b0;
    total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL rst_mid_out: got %b want %b", bus.output_vals, 8'h00); end
    total++; if (bus.cfg_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", bus.cfg_valid); end
    total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", bus.cfg_done); end
    step(3);
    total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL rst_mid_idle: got %b want %b", bus.output_vals, 8'h00); end
    shift_bits(img_a, SR_LEN);
    bus.cfg_en = 1'b0;
    total++; if (pre_valid !== 1'b0) begin bad++; $display("FAIL rst_full_len_valid: got %b want 0", pre_valid); end
    total++; if (pre_out !== 8'h00) begin bad++; $display("FAIL rst_full_len_out: got %b want %b", pre_out, 8'h00); end
    total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL rst_reload_done: got %b want 1", bus.cfg_done); end
    total++; if (bus.output_vals !== 8'b0000_0101) begin bad++; $display("FAIL rst_reload_out: got %b want %b", bus.output_vals, 8'b0000_0101); end
  endtask

  task automatic test_back_to_back();
    bus.input_vars = 8'h01;
    shift_bits(img_a, SR_LEN);
    total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", bus.cfg_done); end
    shift_bits(img_b, SR_LEN);
    bus.cfg_en = 1'b0;
    total++; if (pre_done !== 1'b0) begin bad++; $display("FAIL b2b_early_done: got %b want 0", pre_done); end
    total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL b2b_second_done: got %b want 1", bus.cfg_done); end
    total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL b2b_out0: got %b want %b", bus.output_vals, 8'h00); end
    step(1);
    total++; if (bus.output_vals !== 8'h01) begin bad++; $display("FAIL b2b_out1: got %b want %b", bus.output_vals, 8'h01); end
    step(1);
    total++; if (bus.output_vals !== 8'h00) begin bad++; $display("FAIL b2b_out2: got %b want %b", bus.output_vals, 8'h00); end
  endtask

  initial begin
    // Image A: term0 = I0 & ~I1 -> OR0, OR1; MC1 registered; MC2 inverted
    // with no sum; OR3 fed only by blank term5.
    img_a = '0;
    img_a[0]   = 1'b1;  // term0, column 0  (I0)
    img_a[24]  = 1'b1;  // term0, column 3  (~I1)
    img_a[256] = 1'b1;  // OR0 <- term0
    img_a[264] = 1'b1;  // OR1 <- term0
    img_a[285] = 1'b1;  // OR3 <- term5 (blank)
    img_a[322] = 1'b1;  // MC1 REG
    img_a[325] = 1'b1;  // MC2 INV
    // Image B: term1 = ~FB0 -> OR0, MC0 registered (toggle flop).
    img_b = '0;
    img_b[137] = 1'b1;  // term1, column 17 (~FB0)
    img_b[257] = 1'b1;  // OR0 <- term1
    img_b[320] = 1'b1;  // MC0 REG

    test_reset();
    test_load_comb_reg();
    test_inv_blank();
    test_feedback();
    test_reload_abort();
    test_reset_mid_reload();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
